// File: rtl/card_game_pkg.sv
// Shared types and helpers for the multi-player card game controller.
package card_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDeal,
    StWait,
    StDraw,
    StResult
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // WIN is {no_winner, index}; the flag sits just above the player index.
  function automatic int unsigned no_winner_pos(input int unsigned nplayer);
    return $clog2(nplayer);
  endfunction

  // Masks are widened to the 8-player maximum before using these helpers.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [2:0] lowest_set8(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR mapped onto card values 1..CARD_MAX.
module card_lfsr #(
  parameter int unsigned CARDW    = 4,
  parameter int unsigned CARD_MAX = 10,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CARDW-1:0] rnd
);
  import card_game_pkg::*;

  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic [CARDW-1:0] field;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign field = lfsr_q[CARDW+3:4];
  assign rnd   = (field % CARDW'(CARD_MAX)) + CARDW'(1);

endmodule

// File: rtl/multi_player_card_game.sv
// Deals to NPLAYER hands, serves masked draw rounds, tracks busts and reports one winner.
module multi_player_card_game #(
  parameter int unsigned NPLAYER  = 4,
  parameter int unsigned MAXH     = 21,
  parameter int unsigned CARD_MAX = 10,
  parameter int unsigned CARDW    = 4,
  parameter int unsigned SUMW     = 5,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned PW       = $clog2(NPLAYER)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               IN_VALID,
  input  logic               BUTTON,
  input  logic [NPLAYER-1:0] MORE,
  input  logic               TEST_EN,
  input  logic [CARDW-1:0]   TEST_CARD,
  output logic               OUT_VALID,
  output logic [CARDW-1:0]   CARD,
  output logic [PW-1:0]      PLAYER,
  output logic               DONE,
  output logic [PW:0]        WIN,
  output logic [SUMW-1:0]    SUM
);
  import card_game_pkg::*;

  localparam int unsigned     NoWin  = no_winner_pos(NPLAYER);
  localparam logic [SUMW-1:0] MaxSum = SUMW'(MAXH);

  function automatic logic [7:0] widen(input logic [NPLAYER-1:0] v);
    logic [7:0] w;
    w = '0;
    w[NPLAYER-1:0] = v;
    return w;
  endfunction

  logic                          in_valid_q, button_q;
  logic [NPLAYER-1:0]            more_q;
  logic                          req;

  state_e                        state_q, state_d;
  logic [PW-1:0]                 ptr_q, ptr_d;
  logic [NPLAYER-1:0]            eff_q, eff_d;
  logic [NPLAYER-1:0]            bust_q, bust_d;
  logic [NPLAYER-1:0][SUMW-1:0]  sum_q, sum_d;

  logic [CARDW-1:0]              rnd, card;
  logic                          deal, last;
  logic [PW-1:0]                 deal_p;
  logic [SUMW:0]                 add_w;
  logic [SUMW-1:0]               new_sum;

  logic [SUMW-1:0]               best;
  logic [PW-1:0]                 best_idx;
  logic                          any_alive;
  logic [3:0]                    best_cnt;
  logic [PW:0]                   win_d;
  logic [SUMW-1:0]               win_sum_d;

  logic                          out_valid_q, done_q;
  logic [CARDW-1:0]              card_q;
  logic [PW-1:0]                 player_q;
  logic [PW:0]                   win_q;
  logic [SUMW-1:0]               sum_out_q;

  card_lfsr #(
    .CARDW    (CARDW),
    .CARD_MAX (CARD_MAX),
    .SEED     (SEED)
  ) u_lfsr (
    .clk   (CLK),
    .rst_n (RESET_N),
    .rnd   (rnd)
  );

  assign card = TEST_EN ? TEST_CARD : rnd;
  assign req  = in_valid_q & button_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    eff_d   = eff_q;
    bust_d  = bust_q;
    sum_d   = sum_q;
    deal    = 1'b0;
    last    = 1'b0;
    deal_p  = '0;
    add_w   = '0;
    new_sum = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          sum_d   = '0;
          bust_d  = '0;
          ptr_d   = '0;
          state_d = StDeal;
        end
      end
      StDeal: begin
        deal   = 1'b1;
        deal_p = ptr_q;
        ptr_d  = ptr_q + PW'(1);
        last   = (ptr_q == PW'(NPLAYER - 1));
      end
      StWait: begin
        if (req) begin
          eff_d   = more_q & ~bust_q;
          state_d = (eff_d == '0) ? StResult : StDraw;
        end
      end
      StDraw: begin
        deal          = 1'b1;
        deal_p        = PW'(lowest_set8(widen(eff_q)));
        eff_d[deal_p] = 1'b0;
        last          = (eff_d == '0);
      end
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (deal) begin
      add_w          = {1'b0, sum_q[deal_p]} + (SUMW+1)'(card);
      new_sum        = add_w[SUMW] ? '1 : add_w[SUMW-1:0];
      sum_d[deal_p]  = new_sum;
      bust_d[deal_p] = (new_sum > MaxSum);
      // End check sees the bust state including the card just dealt.
      if (last) state_d = (popcount8(widen(~bust_d)) <= 4'd1) ? StResult : StWait;
    end
  end

  // Winner scan: highest live sum, then count how many live hands share it.
  always_comb begin
    best      = '0;
    best_idx  = '0;
    any_alive = 1'b0;
    best_cnt  = '0;
    win_d     = '0;
    win_sum_d = '0;
    for (int i = 0; i < NPLAYER; i++) begin
      if (!bust_q[i] && (!any_alive || sum_q[i] > best)) begin
        best      = sum_q[i];
        best_idx  = PW'(i);
        any_alive = 1'b1;
      end
    end
    for (int i = 0; i < NPLAYER; i++) begin
      if (!bust_q[i] && sum_q[i] == best) best_cnt = best_cnt + 4'd1;
    end
    if (any_alive && best_cnt == 4'd1) begin
      win_d[PW-1:0] = best_idx;
      win_sum_d     = best;
    end else begin
      win_d[NoWin] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_valid_q  <= 1'b0;
      button_q    <= 1'b0;
      more_q      <= '0;
      state_q     <= StIdle;
      ptr_q       <= '0;
      eff_q       <= '0;
      bust_q      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      card_q      <= '0;
      player_q    <= '0;
      done_q      <= 1'b0;
      win_q       <= {1'b1, {PW{1'b0}}};
      sum_out_q   <= '0;
    end else begin
      in_valid_q  <= IN_VALID;
      button_q    <= BUTTON;
      more_q      <= MORE;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      eff_q       <= eff_d;
      bust_q      <= bust_d;
      sum_q       <= sum_d;
      out_valid_q <= deal;
      if (deal) begin
        card_q   <= card;
        player_q <= deal_p;
      end
      done_q <= (state_q == StResult);
      if (state_q == StResult) begin
        win_q     <= win_d;
        sum_out_q <= win_sum_d;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign CARD      = card_q;
  assign PLAYER    = player_q;
  assign DONE      = done_q;
  assign WIN       = win_q;
  assign SUM       = sum_out_q;

endmodule

// File: doc/multi_player_card_game.md
Name: multi_player_card_game

Overview:
Parametrised successor to the two-hand card-game controller. It deals cards to NPLAYER hands. Each draw round serves a bitmask of requesting players. Players whose sum exceeds MAXH are marked busted, and the block declares a single winner or "no winner". It sits behind the button/valid front panel and drives the card/sum display. A test mode replaces the random source with a forced card value.

Parameters:
NPLAYER, 4, number of hands (2..8); PW = $clog2(NPLAYER)
MAXH, 21, highest non-bust sum
CARD_MAX, 10, largest card value; cards are 1..CARD_MAX
CARDW, 4, card width; CARD_MAX < 2**CARDW
SUMW, 5, hand-sum width; MAXH + CARD_MAX < 2**SUMW
SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
IN_VALID  in  1  request qualifier
BUTTON  in  1  request strobe; a request is IN_VALID && BUTTON, sampled after the sync stage
MORE  in  NPLAYER  draw-request mask, bit i = player i
TEST_EN  in  1  1: dealt cards come from TEST_CARD
TEST_CARD  in  CARDW  forced card value (1..CARD_MAX)
OUT_VALID  out  1  CARD/PLAYER valid this cycle
CARD  out  CARDW  card dealt
PLAYER  out  PW  recipient of CARD
DONE  out  1  one-cycle pulse; WIN/SUM valid
WIN  out  PW+1  {no_winner, index}
SUM  out  SUMW  winning sum, 0 when no_winner

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all sums 0; bust mask 0; LFSR=SEED.
  - Output reset values: OUT_VALID=0, CARD=0, PLAYER=0, DONE=0, WIN={1,0}, SUM=0.
  - A reset asserted mid-game aborts it immediately. No card or result is emitted.
- Sync stage: IN_VALID, BUTTON and MORE pass through one register stage. A request is seen 2 cycles after the pins.
- LFSR: 16-bit Galois, taps 16'hB400, advances every cycle.
  - rnd = (lfsr[CARDW+3:4] % CARD_MAX) + 1.
  - card = TEST_EN ? TEST_CARD : rnd.
- States: IDLE, DEAL, WAIT, DRAW, RESULT.
  - IDLE: on request, clear sums and bust mask, set ptr=0, go to DEAL. MORE is ignored.
  - DEAL: one card per cycle to players 0..NPLAYER-1 in order, so NPLAYER cycles. Then apply the end check.
  - WAIT: on request, latch eff = MORE & ~bust.
    - eff==0: go to RESULT.
    - Otherwise go to DRAW.
  - DRAW: one card per cycle to each set bit of eff, lowest index first. Popcount(eff) cycles. Then apply the end check.
  - End check: if active (non-busted) count <= 1, go to RESULT. Otherwise go to WAIT.
  - RESULT: one cycle. DONE=1, then go to IDLE.
- Requests arriving in DEAL, DRAW or RESULT are dropped, not queued.
- Each dealt card:
  - sum[p] <= sum[p] + card, saturating at 2**SUMW-1.
  - bust[p] <= (new sum > MAXH).
  - In the same cycle, register OUT_VALID=1, CARD=card, PLAYER=p. Outputs appear 1 cycle after the deal-state cycle.
  - OUT_VALID=0 otherwise, with CARD and PLAYER holding their last value.
- Winner: the highest sum among non-busted players.
  - A unique maximum gives WIN={0,idx}, SUM=max.
  - A tie at the maximum, or all players busted, gives WIN={1,0}, SUM=0.
  - WIN and SUM are registered with DONE and hold until the next DONE or reset.

Decomposition:
- card_game_pkg:
  - state enum
  - LFSR_TAPS=16'hB400
  - no_winner bit position helper
  - popcount/priority-encode functions
- Sub-module card_lfsr (seeded LFSR plus card mapping, parameters CARDW/CARD_MAX/SEED).
- Top holds the FSM, sync stage, sum/bust registers and winner compare. This is a combinational max-scan over NPLAYER, registered in RESULT.

Test Plan:
(NPLAYER=4, MAXH=21, CARD_MAX=10, TEST_EN=1 unless noted)
- Reset test: pulse RESET_N low mid-cycle -> outputs go to reset values immediately: OUT_VALID=0, DONE=0, WIN=3'b100, SUM=0.
- Tie, no winner: request with TEST_CARD=5 -> 4 consecutive OUT_VALID with PLAYER 0,1,2,3, CARD=5. Then request with MORE=4'b0000 -> DONE, WIN=3'b100, SUM=0.
- Single draw: TEST_CARD=10 deal, then MORE=4'b0001 with TEST_CARD=3 -> one OUT_VALID, PLAYER=0, CARD=3. Then MORE=0 -> WIN=3'b000, SUM=13.
- Bust and masking (TEST_CARD=10 throughout):
  - Deal, then MORE=4'b1110 -> players 1,2,3 each reach 20.
  - MORE=4'b0110 -> PLAYER 1 then 2, both reach 30 and bust.
  - MORE=4'b0110 again -> eff=0 -> DONE, WIN=3'b011, SUM=20.
- Auto end: 10 deal, MORE=4'b1111 (20 each), MORE=4'b1110 -> players 1-3 bust. DONE then follows without a further request: WIN=3'b000, SUM=20.
- Abort and random mode: reset during DRAW -> no DONE, next game restarts from IDLE. With TEST_EN=0, every dealt CARD is in 1..10 and the sequence matches the LFSR reference model from SEED.
